// File: rtl/stopwatch_pkg.sv
// Shared definitions for the tick-enabled MM:SS stopwatch.
//   state_e        : control FSM encoding (IDLE / RUN / PAUSE)
//   BCD_MAX_UNITS  : top value of a BCD units digit
//   SEC_TENS_MAX   : top value of the seconds tens digit
//   bcd_to_bin()   : two BCD digits -> binary value (minute modulus compare)
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_e;

  localparam int unsigned BCD_MAX_UNITS = 9;
  localparam int unsigned SEC_TENS_MAX  = 5;

  function automatic logic [7:0] bcd_to_bin(input logic [3:0] tens,
                                            input logic [3:0] ones);
    return (8'(tens) * 8'd10) + 8'(ones);
  endfunction

endpackage

// File: rtl/tick_stopwatch_bcd_digit_counter.sv
// Single BCD digit counter with parameterised top value.
//   clk, rst  : system clock, async active-high reset
//   en        : advance by one this cycle
//   clr       : synchronous clear to 0 (wins over en)
//   wrap_now  : force the next advance to roll over to 0 (dynamic modulus)
//   q         : current digit value, 0..MAX_VAL
//   carry     : combinational, high when an enabled advance rolls over
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int unsigned MAX_VAL = BCD_MAX_UNITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       wrap_now,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] q_q, q_d;
  logic       at_top;

  always_comb begin
    // >= keeps the digit inside its legal range even from an unexpected value
    at_top = (q_q >= 4'(MAX_VAL)) || wrap_now;
    q_d    = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = at_top ? '0 : q_q + 4'd1;
    end
    carry = en && at_top;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/tick_stopwatch.sv
// MM:SS BCD stopwatch clocked by clk, advanced by the divider's tick enable.
//   clk, rst        : system clock, async active-high reset
//   tick            : one-cycle enable pulse, TICKS_PER_SEC per second
//   start_stop      : pulse, IDLE->RUN, RUN->PAUSE, PAUSE->RUN
//   clear           : pulse, back to 00:00 / IDLE (highest priority)
//   lap             : pulse, toggles display hold (RUN/PAUSE only)
//   sec_ones..min_tens : BCD digits shown (held value while lap_active)
//   running         : high in RUN
//   lap_active      : high while the display is held
//   wrap            : one-cycle pulse after the count rolls to 00:00
module tick_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 1,
  parameter int unsigned MIN_MODULUS   = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  state_e      state_q, state_d;
  logic [7:0]  presc_q, presc_d;
  logic        lap_q, lap_d;
  logic [15:0] hold_q, hold_d;
  logic        running_q, wrap_q, wrap_d;

  logic        count_en, sec_en, min_wrap_now;
  logic [3:0]  so, st, mo, mt;
  logic        c_so, c_st, c_mo, c_mt;

  // A tick counts only in RUN and never alongside clear; start_stop in RUN
  // still lets the tick count because state_q is used here.
  assign count_en     = (state_q == RUN) && tick && !clear;
  assign sec_en       = count_en && (presc_q == 8'(TICKS_PER_SEC - 1));
  assign min_wrap_now = (bcd_to_bin(mt, mo) == 8'(MIN_MODULUS - 1));

  bcd_digit_counter #(.MAX_VAL(BCD_MAX_UNITS)) u_sec_ones (
    .clk(clk), .rst(rst), .en(sec_en), .clr(clear), .wrap_now(1'b0),
    .q(so), .carry(c_so)
  );
  bcd_digit_counter #(.MAX_VAL(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .en(c_so), .clr(clear), .wrap_now(1'b0),
    .q(st), .carry(c_st)
  );
  bcd_digit_counter #(.MAX_VAL(BCD_MAX_UNITS)) u_min_ones (
    .clk(clk), .rst(rst), .en(c_st), .clr(clear), .wrap_now(min_wrap_now),
    .q(mo), .carry(c_mo)
  );
  bcd_digit_counter #(.MAX_VAL(BCD_MAX_UNITS)) u_min_tens (
    .clk(clk), .rst(rst), .en(c_mo), .clr(clear), .wrap_now(min_wrap_now),
    .q(mt), .carry(c_mt)
  );

  // Minutes never reach 99, so the minute-tens carry fires only on the
  // modulus rollover at 59 seconds, i.e. exactly the full wrap to 00:00.
  assign wrap_d = c_mt;

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (count_en) begin
      presc_d = sec_en ? '0 : presc_q + 8'd1;
    end
  end

  always_comb begin
    lap_d  = lap_q;
    hold_d = hold_q;
    if (clear) begin
      lap_d = 1'b0;
    end else if (lap && (state_q != IDLE)) begin
      lap_d = !lap_q;
      if (!lap_q) hold_d = {mt, mo, st, so};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      lap_q     <= 1'b0;
      hold_q    <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      lap_q     <= lap_d;
      hold_q    <= hold_d;
      running_q <= (state_d == RUN);
      wrap_q    <= wrap_d;
    end
  end

  assign {min_tens, min_ones, sec_tens, sec_ones} = lap_q ? hold_q : {mt, mo, st, so};
  assign running    = running_q;
  assign lap_active = lap_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_tick_stopwatch.sv
module tb_tick_stopwatch;

  logic clk = 1'b0;
  logic rst, tick, start_stop, clear, lap;
  always #5 clk = ~clk;

  logic [3:0] so [3];
  logic [3:0] st [3];
  logic [3:0] mo [3];
  logic [3:0] mt [3];
  logic       running [3];
  logic       lap_active [3];
  logic       wrap [3];

  tick_stopwatch #(.TICKS_PER_SEC(1), .MIN_MODULUS(60)) u_dut0 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_ones(so[0]), .sec_tens(st[0]), .min_ones(mo[0]), .min_tens(mt[0]),
    .running(running[0]), .lap_active(lap_active[0]), .wrap(wrap[0])
  );
  tick_stopwatch #(.TICKS_PER_SEC(1), .MIN_MODULUS(2)) u_dut1 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_ones(so[1]), .sec_tens(st[1]), .min_ones(mo[1]), .min_tens(mt[1]),
    .running(running[1]), .lap_active(lap_active[1]), .wrap(wrap[1])
  );
  tick_stopwatch #(.TICKS_PER_SEC(4), .MIN_MODULUS(60)) u_dut2 (
    .clk(clk), .rst(rst), .tick(tick), .start_stop(start_stop), .clear(clear), .lap(lap),
    .sec_ones(so[2]), .sec_tens(st[2]), .min_ones(mo[2]), .min_tens(mt[2]),
    .running(running[2]), .lap_active(lap_active[2]), .wrap(wrap[2])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: elapsed time kept as a plain count of seconds.
  int tps [3] = '{1, 1, 4};
  int mm  [3] = '{60, 2, 60};
  int m_mode  [3];   // 0 idle, 1 counting, 2 paused
  int m_secs  [3];
  int m_presc [3];
  int m_held  [3];
  bit m_lap   [3];
  bit m_wrap  [3];

  function automatic logic [18:0] obs(int i);
    return {mt[i], mo[i], st[i], so[i], running[i], lap_active[i], wrap[i]};
  endfunction

  function automatic logic [18:0] exp_vec(int i);
    int d, mins, s;
    d    = m_lap[i] ? m_held[i] : m_secs[i];
    mins = d / 60;
    s    = d % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10),
            (m_mode[i] == 1), m_lap[i], m_wrap[i]};
  endfunction

  task automatic check_vec(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got mm:ss=%h run/lap/wrap=%b expected mm:ss=%h run/lap/wrap=%b",
               name, got[18:3], got[2:0], exp[18:3], exp[2:0]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_secs[i] = 0; m_presc[i] = 0;
      m_held[i] = 0; m_lap[i] = 1'b0; m_wrap[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit t, input bit ss, input bit c, input bit l);
    int old;
    m_wrap[i] = 1'b0;
    if (c) begin
      m_mode[i] = 0; m_secs[i] = 0; m_presc[i] = 0; m_lap[i] = 1'b0;
    end else begin
      old = m_secs[i];
      if (m_mode[i] == 1 && t) begin
        m_presc[i]++;
        if (m_presc[i] == tps[i]) begin
          m_presc[i] = 0;
          m_secs[i]++;
          if (m_secs[i] == mm[i] * 60) begin
            m_secs[i] = 0;
            m_wrap[i] = 1'b1;
          end
        end
      end
      if (l && m_mode[i] != 0) begin
        if (!m_lap[i]) begin
          m_held[i] = old;
          m_lap[i]  = 1'b1;
        end else begin
          m_lap[i] = 1'b0;
        end
      end
      if (ss) m_mode[i] = (m_mode[i] == 1) ? 2 : 1;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1 with all models checked.
  task automatic step(input bit t, input bit ss, input bit c, input bit l);
    tick = t; start_stop = ss; clear = c; lap = l;
    @(posedge clk);
    #1;
    tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      model_step(i, t, ss, c, l);
      check_vec($sformatf("model%0d", i), obs(i), exp_vec(i));
    end
  endtask

  // Pulses rst between clock edges and checks the immediate effect.
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) check_vec($sformatf("async_rst%0d", i), obs(i), 19'd0);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int          reps;
    bit          t, ss, c, l;
    logic [15:0] bcd;
    bit          run, lp, wr;
  } vec_t;

  vec_t tbl [17];
  bit   seen_wrap;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
    model_reset();
    #16 rst = 1'b0;
    for (int i = 0; i < 3; i++) check_vec($sformatf("reset%0d", i), obs(i), 19'd0);

    // Instance 0 (1 tick/s, 60 min): pause, lap and clear interactions
    tbl[0]  = '{1,  0, 1, 0, 0, 16'h0000, 1, 0, 0};
    tbl[1]  = '{9,  1, 0, 0, 0, 16'h0009, 1, 0, 0};
    tbl[2]  = '{1,  1, 1, 0, 0, 16'h0010, 0, 0, 0};
    tbl[3]  = '{5,  1, 0, 0, 0, 16'h0010, 0, 0, 0};
    tbl[4]  = '{1,  0, 1, 0, 0, 16'h0010, 1, 0, 0};
    tbl[5]  = '{3,  1, 0, 0, 0, 16'h0013, 1, 0, 0};
    tbl[6]  = '{7,  1, 0, 0, 0, 16'h0020, 1, 0, 0};
    tbl[7]  = '{1,  0, 0, 0, 1, 16'h0020, 1, 1, 0};
    tbl[8]  = '{10, 1, 0, 0, 0, 16'h0020, 1, 1, 0};
    tbl[9]  = '{1,  0, 0, 0, 1, 16'h0030, 1, 0, 0};
    tbl[10] = '{12, 1, 0, 0, 0, 16'h0042, 1, 0, 0};
    tbl[11] = '{1,  0, 0, 0, 1, 16'h0042, 1, 1, 0};
    tbl[12] = '{1,  1, 0, 1, 0, 16'h0000, 0, 0, 0};
    tbl[13] = '{1,  0, 0, 0, 1, 16'h0000, 0, 0, 0};
    tbl[14] = '{1,  0, 1, 0, 1, 16'h0000, 1, 0, 0};
    tbl[15] = '{1,  1, 0, 0, 1, 16'h0000, 1, 1, 0};
    tbl[16] = '{1,  0, 1, 0, 1, 16'h0001, 0, 0, 0};

    for (int k = 0; k < 17; k++) begin
      repeat (tbl[k].reps) step(tbl[k].t, tbl[k].ss, tbl[k].c, tbl[k].l);
      check_vec($sformatf("tbl%0d", k), obs(0),
                {tbl[k].bcd, tbl[k].run, tbl[k].lp, tbl[k].wr});
    end

    // 75 seconds -> 01:15, no wrap
    async_reset();
    step(0, 1, 0, 0);
    seen_wrap = 1'b0;
    repeat (75) begin
      step(1, 0, 0, 0);
      if (wrap[0]) seen_wrap = 1'b1;
    end
    check_vec("s1_0115", obs(0), {16'h0115, 1'b1, 1'b0, 1'b0});
    check_vec("s1_nowrap", 19'(seen_wrap), 19'd0);

    // Instance 1 (2-minute modulus): full wrap pulse
    async_reset();
    step(0, 1, 0, 0);
    repeat (119) step(1, 0, 0, 0);
    check_vec("s3_0159", obs(1), {16'h0159, 1'b1, 1'b0, 1'b0});
    step(1, 0, 0, 0);
    check_vec("s3_wrap", obs(1), {16'h0000, 1'b1, 1'b0, 1'b1});
    step(0, 0, 0, 0);
    check_vec("s3_wrap_end", obs(1), {16'h0000, 1'b1, 1'b0, 1'b0});
    step(1, 0, 0, 0);
    check_vec("s3_continue", obs(1), {16'h0001, 1'b1, 1'b0, 1'b0});

    // Instance 2 (4 ticks/s): prescaler, async abort, prescaler cleared
    async_reset();
    step(0, 1, 0, 0);
    repeat (7) step(1, 0, 0, 0);
    check_vec("s6_0001", obs(2), {16'h0001, 1'b1, 1'b0, 1'b0});
    #1 rst = 1'b1;
    #1 check_vec("s6_async", obs(2), 19'd0);
    model_reset();
    #1 rst = 1'b0;
    step(1, 0, 0, 0);
    check_vec("s6_notick", obs(2), 19'd0);
    step(0, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);
    check_vec("s6_presc3", obs(2), {16'h0000, 1'b1, 1'b0, 1'b0});
    step(1, 0, 0, 0);
    check_vec("s6_presc4", obs(2), {16'h0001, 1'b1, 1'b0, 1'b0});

    // Random traffic against the model on all three configurations
    async_reset();
    repeat (3000) begin
      if ($urandom_range(0, 999) == 0) async_reset();
      else step($urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0,
                $urandom_range(0, 399) == 0, $urandom_range(0, 14) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_stopwatch.md
Name: tick_stopwatch

Overview:
- Counts elapsed MM:SS in BCD and drives the display stage.
- Sits directly downstream of the clock divider. It consumes the divider's one-cycle tick pulse as a clock enable, so the whole block runs on the system clock.
- Provides start/stop, clear and lap-hold control from already-debounced single-cycle button pulses.

Parameters:
- TICKS_PER_SEC, default 1: number of tick pulses per counted second, 1..255.
- MIN_MODULUS, default 60: minute wrap modulus, 1..99.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- tick  in  1  one-cycle enable pulse from the clock divider
- start_stop  in  1  one-cycle pulse; toggles run/pause
- clear  in  1  one-cycle pulse; returns to 00:00, stopped
- lap  in  1  one-cycle pulse; toggles display hold
- sec_ones  out  4  BCD seconds units
- sec_tens  out  4  BCD seconds tens, 0..5
- min_ones  out  4  BCD minutes units
- min_tens  out  4  BCD minutes tens
- running  out  1  high in RUN
- lap_active  out  1  high while display is held
- wrap  out  1  one-cycle pulse on wrap to 00:00

Behaviour:
- Reset (async, rst=1): state IDLE, all digits 0, prescaler 0, lap_active 0, running 0, wrap 0, held display regs 0.
- Clock usage: the block runs on clk only. tick is never used as a clock.
- States:
  - IDLE: count 00:00, stopped.
  - RUN: counting.
  - PAUSE: stopped, count retained.
- Transitions (input priority: clear > start_stop > lap):
  - clear from any state -> IDLE. Count, prescaler and lap_active are zeroed.
  - start_stop: IDLE -> RUN, RUN -> PAUSE, PAUSE -> RUN.
- Counting:
  - Only in RUN, and only on cycles where tick=1.
  - The prescaler counts 0..TICKS_PER_SEC-1. The seconds increment on the tick that wraps the prescaler.
  - Pausing keeps the prescaler value. Clear zeroes it.
- Cascade:
  - sec_ones 9->0 carries into sec_tens.
  - sec_tens 5->0 with sec_ones 9 carries into minutes.
  - Minutes form a two-digit BCD value. It wraps to 00 when it reaches MIN_MODULUS.
  - The full wrap (minutes at MIN_MODULUS-1, seconds at 59 -> 00:00) asserts wrap for exactly the one cycle after the increment. Counting continues after the wrap.
- Latency: an increment caused by a tick at cycle N is visible on the outputs at cycle N+1 (registered).
- Simultaneous events:
  - tick with start_stop in RUN: the tick is counted, then the block enters PAUSE.
  - tick with start_stop in IDLE/PAUSE: the tick is not counted.
  - tick with clear: the tick is ignored and the result is 00:00.
  - lap with start_stop: both take effect.
  - lap with clear: clear wins, and lap_active ends at 0.
- Lap:
  - Accepted in RUN or PAUSE. Ignored in IDLE.
  - lap while lap_active=0: latch the live count into the hold regs and set lap_active. The digit outputs then show the held value while the live count keeps running.
  - lap while lap_active=1: clear lap_active. The outputs show the live count from the next cycle.
- running = (state==RUN), registered. wrap is registered.
- Digit outputs never exceed their legal BCD range under any input sequence.
- rst asserted mid-count aborts immediately. No pending carry or wrap pulse survives reset.

Decomposition:
- Shared package (stopwatch_pkg) holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.
  - BCD_MAX_UNITS=9 and SEC_TENS_MAX=5.
- Sub-module bcd_digit_counter is natural and is instantiated four times. It is a single BCD digit with:
  - a parameterised max value;
  - inputs clk, rst, en, clr, and a dynamic wrap-now override for the minute modulus;
  - outputs q[3:0] and carry.
- The top holds the FSM, prescaler, lap hold regs and output muxing.

Test Plan:
- Reset, then start_stop, then 75 ticks (TICKS_PER_SEC=1) -> outputs 01:15, running=1, wrap never asserted.
- start_stop after 10 ticks, then 5 more ticks, then start_stop and 3 ticks -> after pause display stays 00:10; final 00:13; the pause-cycle tick coincident with start_stop counts (00:10 includes it).
- MIN_MODULUS=2, run 119 ticks to 01:59, then one tick -> 00:00 next cycle, wrap=1 for exactly one cycle.
- lap at 00:20, 10 more ticks -> outputs hold 00:20 with lap_active=1; second lap -> outputs 00:30 next cycle, lap_active=0.
- clear together with tick at 00:42 while RUN and lap_active=1 -> 00:00, IDLE, running=0, lap_active=0; a later lap pulse in IDLE leaves lap_active=0.
- TICKS_PER_SEC=4: 7 ticks -> 00:01; assert rst asynchronously between clk edges -> all outputs 0 immediately, and a following tick is not counted until start_stop.
